// File: rtl/regfile_sb.sv
// regfile_sb: integer register file for the pipelined RV32/RV64 core.
// One clocked write port, two combinational read ports, register 0 tied
// to zero, and a per-register busy scoreboard (set at issue, cleared at
// writeback) used by decode for RAW hazard detection.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding on both read ports.

// One architectural register (r != 0) plus its busy bit.
module regfile_sb_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_set,
  input  logic            i_clr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy,
  output logic            o_busy_nxt
);
  logic [XLEN-1:0] r_data;
  logic            r_busy;

  // Next busy: a new producer issued on the writeback edge keeps it busy.
  always_comb begin
    o_busy_nxt = r_busy;
    if (i_set)      o_busy_nxt = 1'b1;
    else if (i_clr) o_busy_nxt = 1'b0;
  end

  // Data and busy state; the write always lands, even if re-issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_clr) r_data <= i_wdata;
      r_busy <= o_busy_nxt;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;
endmodule

module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic [AW:0]     busy_cnt
);
  logic [NREGS-1:0][XLEN-1:0] w_rf;
  logic [NREGS-1:0]           w_busy;
  logic [NREGS-1:0]           w_busy_nxt;
  logic [AW:0]                w_cnt_nxt;
  logic [AW:0]                r_busy_cnt;

  // Register 0 is hardwired: never stored, never busy.
  assign w_rf[0]       = '0;
  assign w_busy[0]     = 1'b0;
  assign w_busy_nxt[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    regfile_sb_entry #(.XLEN(XLEN)) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_set      (iss_en && (iss_addr == AW'(r))),
      .i_clr      (wr_en && (wr_addr == AW'(r))),
      .i_wdata    (wr_data),
      .o_data     (w_rf[r]),
      .o_busy     (w_busy[r]),
      .o_busy_nxt (w_busy_nxt[r])
    );
  end

  // Population count of the next busy vector so the count tracks the bits.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
  end

  // Registered busy count, updated on the same edge as the busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy_cnt <= '0;
    else        r_busy_cnt <= w_cnt_nxt;
  end

  assign busy_cnt = r_busy_cnt;

  // Read port A; with bypass, a matching writeback is forwarded and busy
  // reflects only a producer issued on this same edge.
  always_comb begin
    rd_data_a = w_rf[rd_addr_a];
    busy_a    = w_busy[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      busy_a    = iss_en && (iss_addr == rd_addr_a);
    end
`endif
  end

  // Read port B, identical to port A.
  always_comb begin
    rd_data_b = w_rf[rd_addr_b];
    busy_b    = w_busy[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      busy_b    = iss_en && (iss_addr == rd_addr_b);
    end
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a scoreboard queue of expected reads.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   rd_addr_a = '0, rd_addr_b = '0;
  logic [XLEN-1:0] rd_data_a, rd_data_b;
  logic            busy_a, busy_b;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [XLEN-1:0] wr_data = '0;
  logic            iss_en = 1'b0;
  logic [AW-1:0]   iss_addr = '0;
  logic [AW:0]     busy_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt)
  );

  typedef struct {
    string           tag;
    logic [XLEN-1:0] da;
    logic            ba;
    logic [XLEN-1:0] db;
    logic            bb;
    logic [AW:0]     cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic push_exp(input string tag, input logic [XLEN-1:0] da, input logic ba,
                          input logic [XLEN-1:0] db, input logic bb, input logic [AW:0] cnt);
    exp_t e;
    e.tag = tag; e.da = da; e.ba = ba; e.db = db; e.bb = bb; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty got=%0d exp=>0", sbq.size());
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      assert (rd_data_a === e.da) else begin
        failures++; $error("FAIL %s rd_data_a got=%h exp=%h", e.tag, rd_data_a, e.da);
      end
      checks++;
      assert (busy_a === e.ba) else begin
        failures++; $error("FAIL %s busy_a got=%b exp=%b", e.tag, busy_a, e.ba);
      end
      checks++;
      assert (rd_data_b === e.db) else begin
        failures++; $error("FAIL %s rd_data_b got=%h exp=%h", e.tag, rd_data_b, e.db);
      end
      checks++;
      assert (busy_b === e.bb) else begin
        failures++; $error("FAIL %s busy_b got=%b exp=%b", e.tag, busy_b, e.bb);
      end
      checks++;
      assert (busy_cnt === e.cnt) else begin
        failures++; $error("FAIL %s busy_cnt got=%0d exp=%0d", e.tag, busy_cnt, e.cnt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; wr_addr = '0; iss_addr = '0; wr_data = '0;
  endtask

  task automatic rd(input int a, input int b);
    rd_addr_a = AW'(a); rd_addr_b = AW'(b); #1;
  endtask

  initial begin
    // Reset held: every address reads zero and not busy.
    #2;
    for (int a = 0; a < NREGS; a++) begin
      push_exp("reset_sweep", '0, 1'b0, '0, 1'b0, '0);
      rd(a, NREGS - 1 - a);
      pop_cmp();
    end
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Plain write to r1.
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1234_5678;
    tick(); idle();
    push_exp("wr_r1", 32'h1234_5678, 1'b0, '0, 1'b0, '0);
    rd(1, 0); pop_cmp();

    // Write and issue to r0 are ignored.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hABCD_EF01; iss_en = 1'b1; iss_addr = 5'd0;
    tick(); idle();
    push_exp("r0_ignored", '0, 1'b0, 32'h1234_5678, 1'b0, '0);
    rd(0, 1); pop_cmp();

    // Issue r5 -> busy; writeback r5 -> clear with data.
    iss_en = 1'b1; iss_addr = 5'd5;
    tick(); idle();
    push_exp("iss_r5", '0, 1'b1, 32'h1234_5678, 1'b0, 6'd1);
    rd(5, 1); pop_cmp();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick(); idle();
    push_exp("wb_r5", 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
    rd(5, 0); pop_cmp();

    // r7 busy, then issue and writeback on the same edge: stays busy, data lands.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick(); idle();
    push_exp("iss_r7", '0, 1'b1, '0, 1'b0, 6'd1);
    rd(7, 0); pop_cmp();
    iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55AA_55AA;
    tick(); idle();
    push_exp("iss_wb_r7", 32'h55AA_55AA, 1'b1, '0, 1'b0, 6'd1);
    rd(7, 0); pop_cmp();

    // Re-issue r7 (no per-register count), then r2 and r9 -> three busy.
    iss_en = 1'b1; iss_addr = 5'd7; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd9; tick(); idle();
    push_exp("multi_busy", 32'h55AA_55AA, 1'b1, '0, 1'b1, 6'd3);
    rd(7, 9); pop_cmp();

    // Writeback to non-busy r4: data written, busy stays 0, count unchanged.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0011;
    tick(); idle();
    push_exp("wb_nonbusy", 32'h0000_0011, 1'b0, '0, 1'b1, 6'd3);
    rd(4, 2); pop_cmp();

    // Same-cycle read of a register being written.
    rd_addr_a = 5'd3; rd_addr_b = 5'd1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D; #1;
`ifdef REGFILE_BYPASS_EN
    push_exp("fwd_r3_pre", 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 1'b0, 6'd3);
`else
    push_exp("fwd_r3_pre", '0, 1'b0, 32'h1234_5678, 1'b0, 6'd3);
`endif
    pop_cmp();
    tick(); idle();
    push_exp("fwd_r3_post", 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 1'b0, 6'd3);
    rd(3, 1); pop_cmp();

    // Same-cycle read while r6 is both written and re-issued.
    rd_addr_a = 5'd6; rd_addr_b = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h0BAD_CAFE; iss_en = 1'b1; iss_addr = 5'd6; #1;
`ifdef REGFILE_BYPASS_EN
    push_exp("fwd_r6_pre", 32'h0BAD_CAFE, 1'b1, 32'h55AA_55AA, 1'b1, 6'd3);
`else
    push_exp("fwd_r6_pre", '0, 1'b0, 32'h55AA_55AA, 1'b1, 6'd3);
`endif
    pop_cmp();
    tick(); idle();
    push_exp("fwd_r6_post", 32'h0BAD_CAFE, 1'b1, 32'h55AA_55AA, 1'b1, 6'd4);
    rd(6, 7); pop_cmp();

    // Asynchronous reset between edges clears everything immediately.
    #1; rst_n = 1'b0; #1;
    push_exp("async_rst", '0, 1'b0, '0, 1'b0, '0);
    pop_cmp();

    // Write in flight while reset is held is lost.
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0099; iss_en = 1'b1; iss_addr = 5'd1;
    tick(); idle();
    push_exp("rst_drops_wr", '0, 1'b0, '0, 1'b0, '0);
    rd(1, 7); pop_cmp();

    // First edge after reset release works normally.
    @(negedge clk); rst_n = 1'b1;
    #1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0077; iss_en = 1'b1; iss_addr = 5'd8;
    tick(); idle();
    push_exp("post_rst", 32'h0000_0077, 1'b0, '0, 1'b1, 6'd1);
    rd(1, 8); pop_cmp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
